// File: rtl/c4_pkg.sv
// Shared Connect-4 definitions: board geometry, player encodings, pixel colours
// and the piece-drawer FSM state type.
package c4_pkg;

   localparam int NUM_COLS = 7;
   localparam int NUM_ROWS = 6;

   localparam logic [1:0] PLAYER_NONE = 2'd0;
   localparam logic [1:0] PLAYER_1    = 2'd1;
   localparam logic [1:0] PLAYER_2    = 2'd2;

   localparam logic [2:0] COLOUR_BORDER = 3'b000;
   localparam logic [2:0] COLOUR_RED    = 3'b100;
   localparam logic [2:0] COLOUR_YELLOW = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DRAW,
      ST_DONE,
      ST_RELEASE
   } draw_state_t;

   // Player 1 is red; any other drawing player is yellow.
   function automatic logic [2:0] piece_colour(input logic [1:0] p);
      return (p == PLAYER_1) ? COLOUR_RED : COLOUR_YELLOW;
   endfunction

endpackage

// File: rtl/column_heights.sv
// Per-column fill heights: two read ports and one saturating increment port.
// Column index 7 reads back as a full column so it can never be drawn into.
module column_heights
   import c4_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [2:0] rd_col_a,
   output logic [2:0] rd_height_a,
   input  logic [2:0] rd_col_b,
   output logic [2:0] rd_height_b,
   input  logic       inc_en,
   input  logic [2:0] inc_col
);

   logic [2:0] height [NUM_COLS];

   always_comb begin
      rd_height_a = 3'(NUM_ROWS);
      if (rd_col_a < 3'(NUM_COLS))
         rd_height_a = height[rd_col_a];
   end

   always_comb begin
      rd_height_b = 3'(NUM_ROWS);
      if (rd_col_b < 3'(NUM_COLS))
         rd_height_b = height[rd_col_b];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_COLS; i++)
            height[i] <= '0;
      end else if (inc_en && (inc_col < 3'(NUM_COLS)) && (height[inc_col] < 3'(NUM_ROWS))) begin
         height[inc_col] <= height[inc_col] + 3'd1;
      end
   end

endmodule

// File: rtl/piece_drawer.sv
// Responds to the controller's draw/draw_done handshake: finds the landing row,
// rasterises one CELLxCELL piece to the VGA pixel port, then bumps the column height.
module piece_drawer
   import c4_pkg::*;
#(
   parameter int X0   = 24,
   parameter int Y0   = 12,
   parameter int CELL = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [2:0] col_in,
   input  logic       ld_column,
   input  logic       draw,
   input  logic [1:0] player,
   output logic       valid,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       draw_done
);

   localparam int CW = $clog2(CELL);
   localparam logic [CW-1:0] PX_ONE = CW'(1);

   draw_state_t state, state_nx;

   logic [2:0]    col_r;
   logic [2:0]    row_r;
   logic [1:0]    player_r;
   logic          noop_r;
   logic [CW-1:0] dx, dy;
   logic [CW-1:0] dx_nx, dy_nx;
   logic [2:0]    height_valid;
   logic [2:0]    height_setup;
   logic          setup_noop;
   logic          last_px;
   logic          inc_en;

   logic       plot_d, done_d;
   logic [7:0] x_d;
   logic [6:0] y_d;
   logic [2:0] colour_d;

   // Signed intermediates so (NUM_ROWS-1 - row) can never wrap unnoticed.
   function automatic logic [7:0] pix_x(input logic [2:0] col, input logic [CW-1:0] px);
      logic signed [9:0] sum;
      sum = $signed(10'(X0)) + $signed({7'd0, col}) * $signed(10'(CELL)) + $signed(10'(px));
      return 8'(sum);
   endfunction

   function automatic logic [6:0] pix_y(input logic [2:0] row, input logic [CW-1:0] py);
      logic signed [9:0] sum;
      sum = $signed(10'(Y0))
          + ($signed(10'(NUM_ROWS - 1)) - $signed({7'd0, row})) * $signed(10'(CELL))
          + $signed(10'(py));
      return 7'(sum);
   endfunction

   function automatic logic [2:0] pix_colour(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                             input logic [1:0] p);
      return ((px == '0) || (py == '0)) ? COLOUR_BORDER : piece_colour(p);
   endfunction

   column_heights u_heights (
      .clk         (clk),
      .resetn      (resetn),
      .rd_col_a    (col_in),
      .rd_height_a (height_valid),
      .rd_col_b    (col_r),
      .rd_height_b (height_setup),
      .inc_en      (inc_en),
      .inc_col     (col_r)
   );

   assign valid      = (col_in < 3'(NUM_COLS)) && (height_valid < 3'(NUM_ROWS));
   assign setup_noop = (height_setup >= 3'(NUM_ROWS)) || (player_r == PLAYER_NONE);
   assign last_px    = (&dx) && (&dy);
   assign inc_en     = (state == ST_DONE) && !noop_r;

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (draw) state_nx = ST_SETUP;
         ST_SETUP:   state_nx = setup_noop ? ST_DONE : ST_DRAW;
         ST_DRAW:    if (last_px) state_nx = ST_DONE;
         ST_DONE:    state_nx = ST_RELEASE;
         ST_RELEASE: if (!draw) state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Next values of the registered pixel port: each pixel is computed from the
   // counters it will be displayed with, so x/y/colour/plot land together.
   always_comb begin
      plot_d   = 1'b0;
      done_d   = 1'b0;
      x_d      = x;
      y_d      = y;
      colour_d = colour;
      dx_nx    = dx;
      dy_nx    = dy;
      case (state)
         ST_SETUP: begin
            dx_nx = '0;
            dy_nx = '0;
            if (setup_noop) begin
               done_d = 1'b1;
            end else begin
               plot_d   = 1'b1;
               x_d      = pix_x(col_r, '0);
               y_d      = pix_y(height_setup, '0);
               colour_d = pix_colour('0, '0, player_r);
            end
         end
         ST_DRAW: begin
            if (last_px) begin
               done_d = 1'b1;
            end else begin
               dx_nx    = dx + PX_ONE;
               dy_nx    = (&dx) ? dy + PX_ONE : dy;
               plot_d   = 1'b1;
               x_d      = pix_x(col_r, dx_nx);
               y_d      = pix_y(row_r, dy_nx);
               colour_d = pix_colour(dx_nx, dy_nx, player_r);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         plot      <= 1'b0;
         draw_done <= 1'b0;
         x         <= '0;
         y         <= '0;
         colour    <= '0;
         dx        <= '0;
         dy        <= '0;
         col_r     <= '0;
         row_r     <= '0;
         player_r  <= PLAYER_NONE;
         noop_r    <= 1'b0;
      end else begin
         plot      <= plot_d;
         draw_done <= done_d;
         x         <= x_d;
         y         <= y_d;
         colour    <= colour_d;
         dx        <= dx_nx;
         dy        <= dy_nx;
         if ((state == ST_IDLE) && ld_column)
            col_r <= col_in;
         if ((state == ST_IDLE) && draw)
            player_r <= player;
         if (state == ST_SETUP) begin
            row_r  <= height_setup;
            noop_r <= setup_noop;
         end
      end
   end

endmodule

// File: tb/tb_piece_drawer.sv
// Randomised bench for piece_drawer: a queue-based model of each draw transaction
// is compared every cycle, with literal expectations for the directed scenarios.
module tb_piece_drawer;

   logic       clk = 1'b0;
   logic       resetn;
   logic [2:0] col_in;
   logic       ld_column;
   logic       draw;
   logic [1:0] player;
   logic       valid;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       draw_done;

   always #5 clk = ~clk;

   piece_drawer #(.X0(24), .Y0(12), .CELL(16)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .col_in    (col_in),
      .ld_column (ld_column),
      .draw      (draw),
      .player    (player),
      .valid     (valid),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .draw_done (draw_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit plot;
      bit done;
      bit inc;
      int x;
      int y;
      int colour;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   mh[7];
   int   mcol, mplayer;
   int   mode;          // 0 waiting for draw, 1 drawing, 2 waiting for draw to drop
   bit   model_en = 1'b0;

   function automatic void build(input int c, input int p);
      exp_t e;
      e = '{default: 0};
      q.push_back(e);                       // setup cycle
      if (c >= 7 || mh[c] >= 6 || p == 0) begin
         e.done = 1'b1;
         q.push_back(e);
      end else begin
         for (int dy = 0; dy < 16; dy++)
            for (int dx = 0; dx < 16; dx++) begin
               e = '{default: 0};
               e.plot   = 1'b1;
               e.x      = (24 + c * 16 + dx) & 255;
               e.y      = (12 + (5 - mh[c]) * 16 + dy) & 127;
               e.colour = (dx == 0 || dy == 0) ? 0 : ((p == 1) ? 4 : 6);
               q.push_back(e);
            end
         e = '{default: 0};
         e.done = 1'b1;
         e.inc  = 1'b1;
         q.push_back(e);
      end
   endfunction

   always @(posedge clk) begin
      if (!resetn) begin
         q.delete();
         for (int i = 0; i < 7; i++) mh[i] = 0;
         mcol = 0; mplayer = 0; mode = 0;
         cur = '{default: 0};
         model_en = 1'b1;
      end else begin
         if (mode == 0) begin
            if (ld_column) mcol = int'(col_in);
            if (draw) begin
               mplayer = int'(player);
               mode = 1;
               build(mcol, mplayer);
            end
         end else if (mode == 2) begin
            if (!draw) mode = 0;
         end
         if (q.size() > 0) begin
            cur = q.pop_front();
         end else begin
            if (mode == 1) begin
               if (cur.inc) mh[mcol]++;
               mode = 2;
            end
            cur = '{default: 0};
         end
      end
   end

   function automatic int model_valid(input int c);
      return (c <= 6) ? ((mh[c] < 6) ? 1 : 0) : 0;
   endfunction

   always @(negedge clk) begin
      if (model_en) begin
         chk("plot", int'(plot), int'(cur.plot));
         chk("draw_done", int'(draw_done), int'(cur.done));
         chk("valid", int'(valid), model_valid(int'(col_in)));
         if (cur.plot) begin
            chk("x", int'(x), cur.x);
            chk("y", int'(y), cur.y);
            chk("colour", int'(colour), cur.colour);
         end
      end
   end

   // ---------------- stimulus ----------------
   int px_x[$], px_y[$], px_c[$];
   int nplot, done_cyc, hold_plot;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run_draw(input int c, input int p, input bit ld, input int drop_at,
                           input int hold_after, input bit scramble);
      col_in = 3'(c); ld_column = ld; player = 2'(p); draw = 1'b1;
      nplot = 0; done_cyc = 0; hold_plot = 0;
      px_x.delete(); px_y.delete(); px_c.delete();
      step();                                // E0 has just been sampled
      ld_column = 1'b0;
      for (int cyc = 1; cyc <= 400 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         if (plot) begin
            nplot++;
            px_x.push_back(int'(x)); px_y.push_back(int'(y)); px_c.push_back(int'(colour));
         end
         if (draw_done) done_cyc = cyc;
         step();
         if (cyc == drop_at) draw = 1'b0;
         if (scramble) begin
            col_in = 3'($urandom_range(0, 7));
            ld_column = 1'($urandom_range(0, 1));
            player = 2'($urandom_range(0, 2));
         end
      end
      if (done_cyc == 0) chk("draw_done_timeout", 0, 1);
      for (int h = 0; h < hold_after; h++) begin
         @(negedge clk);
         if (plot) hold_plot++;
         step();
      end
      draw = 1'b0; ld_column = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; col_in = 3'd3; ld_column = 1'b0; draw = 1'b0; player = 2'd0;
      repeat (3) step();
      @(negedge clk);
      chk("reset_plot", int'(plot), 0);
      chk("reset_done", int'(draw_done), 0);
      chk("reset_x", int'(x), 0);
      chk("reset_y", int'(y), 0);
      chk("reset_colour", int'(colour), 0);
      chk("reset_valid_col3", int'(valid), 1);
      step();
      resetn = 1'b1;
      step();

      // first piece, column 0, player 1
      run_draw(0, 1, 1'b1, 0, 0, 1'b0);
      chk("p1_plot_count", nplot, 256);
      chk("p1_done_cycle", done_cyc, 258);
      if (nplot == 256) begin
         chk("p1_first_x", px_x[0], 24);
         chk("p1_first_y", px_y[0], 92);
         chk("p1_first_colour", px_c[0], 0);
         chk("p1_pix17_x", px_x[17], 25);
         chk("p1_pix17_y", px_y[17], 93);
         chk("p1_pix17_colour", px_c[17], 4);
         chk("p1_last_x", px_x[255], 39);
         chk("p1_last_y", px_y[255], 107);
      end
      chk("model_height0_a", mh[0], 1);

      // stacking, column 0, player 2
      run_draw(0, 2, 1'b1, 0, 0, 1'b0);
      chk("p2_plot_count", nplot, 256);
      if (nplot == 256) begin
         chk("p2_first_y", px_y[0], 76);
         chk("p2_last_y", px_y[255], 91);
         chk("p2_pix17_colour", px_c[17], 6);
      end
      chk("model_height0_b", mh[0], 2);

      // fill column 6, then a forced seventh drop
      for (int i = 0; i < 6; i++) run_draw(6, (i % 2) + 1, 1'b1, 0, 0, 1'b0);
      col_in = 3'd6;
      step();
      @(negedge clk);
      chk("full_col6_valid", int'(valid), 0);
      step();
      run_draw(6, 1, 1'b1, 0, 0, 1'b0);
      chk("full_plot_count", nplot, 0);
      chk("full_done_cycle", done_cyc, 2);
      @(negedge clk);
      chk("full_still_invalid", int'(valid), 0);
      step();

      // handshake: draw held after completion must not retrigger
      run_draw(3, 1, 1'b1, 0, 5, 1'b0);
      chk("hs_plot_count", nplot, 256);
      chk("hs_hold_plots", hold_plot, 0);
      run_draw(3, 2, 1'b1, 0, 0, 1'b0);
      chk("hs_redraw_count", nplot, 256);
      if (nplot == 256) chk("hs_redraw_y", px_y[0], 76);

      // reset during DRAW cycle 100
      col_in = 3'd1; ld_column = 1'b1; player = 2'd1; draw = 1'b1;
      step();
      ld_column = 1'b0;
      repeat (100) step();
      resetn = 1'b0; draw = 1'b0;
      step();
      @(negedge clk);
      chk("rst_mid_plot", int'(plot), 0);
      col_in = 3'd6; #1;
      chk("rst_mid_valid_col6", int'(valid), 1);
      step();
      resetn = 1'b1;
      step();
      run_draw(1, 2, 1'b1, 0, 0, 1'b0);
      chk("rst_redraw_count", nplot, 256);
      if (nplot == 256) chk("rst_redraw_row0_y", px_y[0], 92);

      // randomised transactions
      for (int n = 0; n < 45; n++) begin
         if ($urandom_range(0, 14) == 0) begin
            resetn = 1'b0; step(); resetn = 1'b1; step();
         end
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            col_in = 3'($urandom_range(0, 7));
            ld_column = 1'($urandom_range(0, 1));
            step();
         end
         run_draw(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 200)) : 0,
                  int'($urandom_range(0, 4)), 1'b1);
      end

      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
